sdram_burst_arbiter: RTL and testbench

- SDRAM-side consumer of the FIFO trigger interface.
- Accepts wr_trig and rd_trig pulses from the write/read FIFO pair. Arbitrates between them and issues one fixed-length burst per trigger to the SDRAM command engine.
- Moves data wfifo -> SDRAM on writes and SDRAM -> rfifo on reads.
- Maintains ping-pong frame buffers: writes fill one bank while reads drain the last completed bank.

---
 rtl/sdram_burst_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_burst_arbiter
//
// Purpose:
//   SDRAM-side consumer of the write/read FIFO trigger pair. Each trigger asks
//   for one fixed-length burst. Write bursts move wfifo -> SDRAM. Read bursts
//   move SDRAM -> rfifo. Write and read requests are arbitrated round robin.
//   Addresses follow a ping-pong frame scheme: writes fill one bank while reads
//   drain the most recently completed bank. The top address bit selects the
//   bank.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_trig, rd_trig    burst request pulses from the FIFO pair
//   wfifo_rd_en/_data   wfifo read strobe; its data is valid 1 cycle later
//   rfifo_wr_en/_data   rfifo write strobe and data (registered)
//   sd_cmd_*            burst command handshake toward the SDRAM engine
//   sd_wr_data_req      engine pulls one write word
//   sd_wr_data          write data to engine, valid 1 cycle after its request
//   sd_rd_data(_valid)  read word stream from engine
//   busy                high whenever the FSM is outside IDLE
//   frame_done          1-cycle pulse when a write frame completes
// -----------------------------------------------------------------------------
module sdram_burst_arbiter #(
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200,
   parameter int ADDR_W      = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_trig,
   input  logic              rd_trig,
   output logic              wfifo_rd_en,
   input  logic [15:0]       wfifo_rd_data,
   output logic              rfifo_wr_en,
   output logic [15:0]       rfifo_wr_data,
   output logic              sd_cmd_req,
   input  logic              sd_cmd_ack,
   output logic              sd_cmd_wr,
   output logic [ADDR_W-1:0] sd_cmd_addr,
   input  logic              sd_wr_data_req,
   output logic [15:0]       sd_wr_data,
   input  logic [15:0]       sd_rd_data,
   input  logic              sd_rd_data_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int OFF_W = ADDR_W - 1;
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   // Offsets live in OFF_W bits, so a frame that spans the whole bank wraps
   // to zero in both the sum and the constant and still compares equal.
   localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);
   localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_CMD  = 3'd1,
      WR_DATA = 3'd2,
      RD_CMD  = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t             state_q;
   logic               wr_pend_q, rd_pend_q;
   logic               wr_pend_d, rd_pend_d;
   logic               last_wr_q;        // 1: last burst served was a write
   logic [CNT_W-1:0]   cnt_q;
   logic [OFF_W-1:0]   wr_off_q, rd_off_q;
   logic               wr_bank_q, rd_bank_q, frame_valid_q;
   logic               cmd_req_q, cmd_wr_q;
   logic [ADDR_W-1:0]  cmd_addr_q;
   logic               rfifo_wr_en_q;
   logic [15:0]        rfifo_wr_data_q;
   logic               wdata_vld_q;      // wfifo word for the engine is on the bus
   logic               busy_q, frame_done_q;

   logic               wr_acked, rd_acked, rd_elig, pick_wr, pick_rd;
   logic               wr_wrap, rd_wrap;
   logic [OFF_W-1:0]   wr_off_nx, rd_off_nx;

   // A trigger in the ack cycle re-arms the flag; a trigger while set is absorbed.
   assign wr_acked  = (state_q == WR_CMD) && sd_cmd_ack;
   assign rd_acked  = (state_q == RD_CMD) && sd_cmd_ack;
   assign wr_pend_d = wr_trig || (wr_pend_q && !wr_acked);
   assign rd_pend_d = rd_trig || (rd_pend_q && !rd_acked);

   // Reads stay gated until a full frame exists to read back.
   assign rd_elig = rd_pend_q && frame_valid_q;
   assign pick_wr = wr_pend_q && (!rd_elig || !last_wr_q);
   assign pick_rd = rd_elig && (!wr_pend_q || last_wr_q);

   assign wr_off_nx = wr_off_q + BURST_OFF;
   assign rd_off_nx = rd_off_q + BURST_OFF;
   assign wr_wrap   = (wr_off_nx == FRAME_OFF);
   assign rd_wrap   = (rd_off_nx == FRAME_OFF);

   // The engine's pull goes straight to the fifo; the fifo answers one cycle
   // later, which is exactly when the engine samples sd_wr_data.
   assign wfifo_rd_en = (state_q == WR_DATA) && sd_wr_data_req;
   assign sd_wr_data  = wdata_vld_q ? wfifo_rd_data : 16'h0000;

   assign rfifo_wr_en   = rfifo_wr_en_q;
   assign rfifo_wr_data = rfifo_wr_data_q;
   assign sd_cmd_req    = cmd_req_q;
   assign sd_cmd_wr     = cmd_wr_q;
   assign sd_cmd_addr   = cmd_addr_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;

   // NOTE: every register here uses <= so all of them update from the same
   // pre-edge values; a blocking = would let later lines see half-updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         wr_pend_q       <= 1'b0;
         rd_pend_q       <= 1'b0;
         last_wr_q       <= 1'b0;
         cnt_q           <= '0;
         wr_off_q        <= '0;
         rd_off_q        <= '0;
         wr_bank_q       <= 1'b0;
         rd_bank_q       <= 1'b1;
         frame_valid_q   <= 1'b0;
         cmd_req_q       <= 1'b0;
         cmd_wr_q        <= 1'b0;
         cmd_addr_q      <= '0;
         rfifo_wr_en_q   <= 1'b0;
         rfifo_wr_data_q <= '0;
         wdata_vld_q     <= 1'b0;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
      end else begin
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         wdata_vld_q   <= wfifo_rd_en;
         frame_done_q  <= 1'b0;
         rfifo_wr_en_q <= (state_q == RD_DATA) && sd_rd_data_valid;
         if ((state_q == RD_DATA) && sd_rd_data_valid)
            rfifo_wr_data_q <= sd_rd_data;

         case (state_q)
            IDLE: begin
               if (pick_wr) begin
                  state_q    <= WR_CMD;
                  cmd_req_q  <= 1'b1;
                  cmd_wr_q   <= 1'b1;
                  cmd_addr_q <= {wr_bank_q, wr_off_q};
                  last_wr_q  <= 1'b1;
                  busy_q     <= 1'b1;
               end else if (pick_rd) begin
                  state_q    <= RD_CMD;
                  cmd_req_q  <= 1'b1;
                  cmd_wr_q   <= 1'b0;
                  cmd_addr_q <= {rd_bank_q, rd_off_q};
                  last_wr_q  <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            WR_CMD, RD_CMD: begin
               if (sd_cmd_ack) begin
                  cmd_req_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= (state_q == WR_CMD) ? WR_DATA : RD_DATA;
               end
            end
            WR_DATA: begin
               if (sd_wr_data_req) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) state_q <= DONE;
               end
            end
            RD_DATA: begin
               if (sd_rd_data_valid) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (cmd_wr_q) begin
                  if (wr_wrap) begin
                     wr_off_q      <= '0;
                     wr_bank_q     <= ~wr_bank_q;
                     frame_valid_q <= 1'b1;
                     frame_done_q  <= 1'b1;
                     // First completed frame: point reads at the bank just filled.
                     if (!frame_valid_q) rd_bank_q <= wr_bank_q;
                  end else begin
                     wr_off_q <= wr_off_nx;
                  end
               end else begin
                  if (rd_wrap) begin
                     rd_off_q  <= '0;
                     rd_bank_q <= ~wr_bank_q;  // latest completed bank
                  end else begin
                     rd_off_q <= rd_off_nx;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_burst_arbiter
//
// Directed bench for sdram_burst_arbiter with BURST_LEN=4, FRAME_WORDS=8,
// ADDR_W=8. Inputs are driven 1 time unit after the rising edge; outputs are
// sampled after that, away from the edge.
// -----------------------------------------------------------------------------
module tb_sdram_burst_arbiter;

   localparam int BL = 4;
   localparam int FW = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_trig, rd_trig;
   logic          wfifo_rd_en;
   logic [15:0]   wfifo_rd_data;
   logic          rfifo_wr_en;
   logic [15:0]   rfifo_wr_data;
   logic          sd_cmd_req, sd_cmd_ack, sd_cmd_wr;
   logic [AW-1:0] sd_cmd_addr;
   logic          sd_wr_data_req;
   logic [15:0]   sd_wr_data;
   logic [15:0]   sd_rd_data;
   logic          sd_rd_data_valid;
   logic          busy, frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   sdram_burst_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
      .clk              (clk),
      .rst              (rst),
      .wr_trig          (wr_trig),
      .rd_trig          (rd_trig),
      .wfifo_rd_en      (wfifo_rd_en),
      .wfifo_rd_data    (wfifo_rd_data),
      .rfifo_wr_en      (rfifo_wr_en),
      .rfifo_wr_data    (rfifo_wr_data),
      .sd_cmd_req       (sd_cmd_req),
      .sd_cmd_ack       (sd_cmd_ack),
      .sd_cmd_wr        (sd_cmd_wr),
      .sd_cmd_addr      (sd_cmd_addr),
      .sd_wr_data_req   (sd_wr_data_req),
      .sd_wr_data       (sd_wr_data),
      .sd_rd_data       (sd_rd_data),
      .sd_rd_data_valid (sd_rd_data_valid),
      .busy             (busy),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig(input logic w, input logic r);
      wr_trig = w;
      rd_trig = r;
      cyc();
      wr_trig = 1'b0;
      rd_trig = 1'b0;
   endtask

   // Waits (bounded) for a command request.
   task automatic wait_req(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (sd_cmd_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_req_timeout: sd_cmd_req got 0, want 1 within 40 cycles", name);
      end
   endtask

   // Command handshake with ack after 3 cycles of stable request.
   task automatic cmd_phase(input string name, input logic [AW-1:0] exp_addr,
                            input logic exp_wr, output bit ok);
      wait_req(name, ok);
      if (!ok) return;
      n_cmp++;
      if (sd_cmd_addr !== exp_addr || sd_cmd_wr !== exp_wr || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_cmd: addr=%h wr=%b busy=%b, want addr=%h wr=%b busy=1",
                  name, sd_cmd_addr, sd_cmd_wr, busy, exp_addr, exp_wr);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if (sd_cmd_req !== 1'b1 || sd_cmd_addr !== exp_addr || sd_cmd_wr !== exp_wr) begin
            n_bad++;
            $display("FAIL %s_cmd_hold%0d: req=%b addr=%h wr=%b, want req=1 addr=%h wr=%b",
                     name, i, sd_cmd_req, sd_cmd_addr, sd_cmd_wr, exp_addr, exp_wr);
         end
      end
      sd_cmd_ack = 1'b1;
      cyc();
      sd_cmd_ack = 1'b0;
      n_cmp++;
      if (sd_cmd_req !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_req_drop: sd_cmd_req got %b, want 0", name, sd_cmd_req);
      end
   endtask

   task automatic run_write(input string name, input logic [AW-1:0] exp_addr,
                            input logic exp_fd);
      bit ok;
      logic [15:0] d;
      cmd_phase(name, exp_addr, 1'b1, ok);
      if (!ok) return;
      for (int k = 0; k < BL; k++) begin
         d = 16'h5a00 ^ {exp_addr, 8'(k)};
         sd_wr_data_req = 1'b1;
         #1;
         n_cmp++;
         if (wfifo_rd_en !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_rd_en%0d: wfifo_rd_en got %b, want 1", name, k, wfifo_rd_en);
         end
         cyc();
         sd_wr_data_req = 1'b0;
         wfifo_rd_data  = d;
         #1;
         n_cmp++;
         if (sd_wr_data !== d || busy !== 1'b1 || wfifo_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_wdata%0d: data=%h busy=%b rd_en=%b, want data=%h busy=1 rd_en=0",
                     name, k, sd_wr_data, busy, wfifo_rd_en, d);
         end
         cyc();
      end
      wfifo_rd_data = 16'hdead;
      n_cmp++;
      if (busy !== 1'b0 || frame_done !== exp_fd) begin
         n_bad++;
         $display("FAIL %s_done: busy=%b frame_done=%b, want busy=0 frame_done=%b",
                  name, busy, frame_done, exp_fd);
      end
      cyc();
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_fd_pulse: frame_done got %b, want 0", name, frame_done);
      end
   endtask

   task automatic run_read(input string name, input logic [AW-1:0] exp_addr,
                           input bit poke_wr);
      bit ok;
      logic [15:0] d;
      cmd_phase(name, exp_addr, 1'b0, ok);
      if (!ok) return;
      for (int k = 0; k < BL; k++) begin
         d = 16'hc300 + 16'(k) + 16'(exp_addr);
         sd_rd_data       = d;
         sd_rd_data_valid = 1'b1;
         if (poke_wr && k == 1) wr_trig = 1'b1;
         #1;
         n_cmp++;
         if (rfifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_early%0d: rfifo_wr_en got %b, want 0", name, k, rfifo_wr_en);
         end
         cyc();
         sd_rd_data_valid = 1'b0;
         wr_trig          = 1'b0;
         sd_rd_data       = 16'hffff;
         #1;
         n_cmp++;
         if (rfifo_wr_en !== 1'b1 || rfifo_wr_data !== d) begin
            n_bad++;
            $display("FAIL %s_rdata%0d: wr_en=%b data=%h, want wr_en=1 data=%h",
                     name, k, rfifo_wr_en, rfifo_wr_data, d);
         end
         cyc();
      end
      n_cmp++;
      if (busy !== 1'b0 || rfifo_wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done: busy=%b rfifo_wr_en=%b, want 0 0", name, busy, rfifo_wr_en);
      end
   endtask

   task automatic expect_no_req(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         cyc();
         if (sd_cmd_req !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL %s: sd_cmd_req seen 1 within %0d cycles, want 0", name, cycles);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      n_cmp++;
      if ({wfifo_rd_en, rfifo_wr_en, rfifo_wr_data, sd_cmd_req, sd_cmd_wr,
           sd_cmd_addr, sd_wr_data, busy, frame_done} !== '0) begin
         n_bad++;
         $display("FAIL %s: rd_en=%b wr_en=%b rdata=%h req=%b wr=%b addr=%h wdata=%h busy=%b fd=%b, want all 0",
                  name, wfifo_rd_en, rfifo_wr_en, rfifo_wr_data, sd_cmd_req, sd_cmd_wr,
                  sd_cmd_addr, sd_wr_data, busy, frame_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr_trig = 1'b0; rd_trig = 1'b0; sd_cmd_ack = 1'b0;
      sd_wr_data_req = 1'b0; sd_rd_data_valid = 1'b0;
      wfifo_rd_data = 16'hbeef; sd_rd_data = 16'h1234;
      cyc(); cyc();
      rst = 1'b0;
      check_outputs_zero("reset_outputs");
      n_cmp++;
      if (dut.wr_off_q !== 7'd0 || dut.rd_off_q !== 7'd0 || dut.wr_bank_q !== 1'b0 ||
          dut.rd_bank_q !== 1'b1 || dut.frame_valid_q !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: wr_off=%0d rd_off=%0d wr_bank=%b rd_bank=%b fv=%b, want 0 0 0 1 0",
                  dut.wr_off_q, dut.rd_off_q, dut.wr_bank_q, dut.rd_bank_q, dut.frame_valid_q);
      end
   endtask

   task automatic test_stray_strobes();
      sd_wr_data_req   = 1'b1;
      sd_rd_data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (wfifo_rd_en !== 1'b0 || rfifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_strobe%0d: rd_en=%b wr_en=%b busy=%b, want 0 0 0",
                     i, wfifo_rd_en, rfifo_wr_en, busy);
         end
         cyc();
      end
      sd_wr_data_req   = 1'b0;
      sd_rd_data_valid = 1'b0;
      n_cmp++;
      if (dut.cnt_q !== 2'd0 || dut.wr_off_q !== 7'd0 || dut.rd_off_q !== 7'd0 || rfifo_wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_counters: cnt=%0d wr_off=%0d rd_off=%0d wr_en=%b, want 0 0 0 0",
                  dut.cnt_q, dut.wr_off_q, dut.rd_off_q, rfifo_wr_en);
      end
   endtask

   task automatic test_read_gating();
      pulse_trig(1'b0, 1'b1);
      expect_no_req("read_gating", 10);
   endtask

   task automatic test_single_write();
      pulse_trig(1'b1, 1'b0);
      run_write("single_write", 8'h00, 1'b0);
      n_cmp++;
      if (dut.wr_off_q !== 7'd4) begin
         n_bad++;
         $display("FAIL single_write_off: wr_off got %0d, want 4", dut.wr_off_q);
      end
      expect_no_req("gated_after_write", 6);
   endtask

   task automatic test_frame_wrap();
      pulse_trig(1'b1, 1'b0);
      run_write("frame_wrap", 8'h04, 1'b1);
      n_cmp++;
      if (dut.frame_valid_q !== 1'b1 || dut.wr_bank_q !== 1'b1 || dut.wr_off_q !== 7'd0) begin
         n_bad++;
         $display("FAIL frame_wrap_state: fv=%b wr_bank=%b wr_off=%0d, want 1 1 0",
                  dut.frame_valid_q, dut.wr_bank_q, dut.wr_off_q);
      end
   endtask

   task automatic test_first_read();
      // The read requested during gating is served now from bank 0.
      run_read("first_read", 8'h00, 1'b0);
   endtask

   task automatic test_bank_switch();
      pulse_trig(1'b1, 1'b0);
      run_write("bank1_write", 8'h80, 1'b0);
   endtask

   task automatic test_contention();
      // Last served was a write, so the read goes first; the extra wr_trig
      // during the read burst is absorbed into the already-pending write.
      pulse_trig(1'b1, 1'b1);
      run_read("contention_read", 8'h04, 1'b1);
      run_write("contention_write", 8'h84, 1'b1);
      expect_no_req("contention_absorbed", 20);
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      pulse_trig(1'b1, 1'b0);
      run_write("pre_reset_write", 8'h00, 1'b0);
      pulse_trig(1'b1, 1'b0);
      cmd_phase("mid_reset", 8'h04, 1'b1, ok);
      for (int k = 0; k < 2; k++) begin
         sd_wr_data_req = 1'b1;
         cyc();
         sd_wr_data_req = 1'b0;
         wfifo_rd_data  = 16'h7700 + 16'(k);
         cyc();
      end
      sd_wr_data_req = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      check_outputs_zero("mid_reset_outputs");
      n_cmp++;
      if (dut.state_q !== 3'd0 || dut.wr_off_q !== 7'd0 || dut.wr_bank_q !== 1'b0 ||
          dut.frame_valid_q !== 1'b0 || dut.rd_bank_q !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset_state: state=%0d wr_off=%0d wr_bank=%b fv=%b rd_bank=%b, want 0 0 0 0 1",
                  dut.state_q, dut.wr_off_q, dut.wr_bank_q, dut.frame_valid_q, dut.rd_bank_q);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if (wfifo_rd_en !== 1'b0 || sd_cmd_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_quiet%0d: rd_en=%b req=%b busy=%b, want 0 0 0",
                     i, wfifo_rd_en, sd_cmd_req, busy);
         end
      end
      sd_wr_data_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stray_strobes();
      test_read_gating();
      test_single_write();
      test_frame_wrap();
      test_first_read();
      test_bank_switch();
      test_contention();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
